// File: rtl/h2_console_arbiter_pkg.sv
// Shared types and helpers for the h2 console arbiter slice.
package h2_console_pkg;

  localparam int CON_W = 8;

  typedef logic [CON_W-1:0] con_byte_t;

  // Round-robin candidate index: (base + off) wrapped into [0, n).
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/h2_console_arbiter_if.sv
// Console output channel: one tagged byte at a time on valid/ready.
interface h2_console_arbiter_if #(
  parameter int NCORE = 4,
  parameter int W     = 8
);
  localparam int SW = $clog2(NCORE);

  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_ready;

  modport master (output out_valid, output out_data, output out_src, input out_ready);
  modport slave  (input out_valid, input out_data, input out_src, output out_ready);
endinterface

// File: rtl/h2_console_arbiter_fifo.sv
// Per-core byte FIFO; a pop frees the slot for a push on the same edge.
module h2_console_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          empty_r;
  logic          full_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign pop_ok_s  = pop & ~empty_r;
  assign push_ok_s = push & (~full_r | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign empty     = empty_r;
  assign full      = full_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CW'(0));
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  // Storage write; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/h2_console_arbiter.sv
// Buffers console bytes from NCORE cores and round-robins them onto one tagged channel.
module h2_console_arbiter
  import h2_console_pkg::*;
#(
  parameter int NCORE = 4,
  parameter int W     = CON_W,
  parameter int DEPTH = 2
) (
  input  logic               phi,
  input  logic               rst_n,
  input  logic [NCORE*W-1:0] cout,
  input  logic [NCORE-1:0]   cstrobe,
  output logic [NCORE-1:0]   cfull,
  output logic [NCORE-1:0]   ovf,
  h2_console_arbiter_if.master con
);
  localparam int SW = $clog2(NCORE);

  logic [NCORE-1:0]        empty_s;
  logic [NCORE-1:0]        full_s;
  logic [NCORE-1:0]        pop_s;
  logic [NCORE-1:0][W-1:0] head_s;
  logic                    free_s;
  logic                    grant_valid_s;
  logic [SW-1:0]           grant_idx_s;
  logic [SW-1:0]           cand_s;
  logic [SW-1:0]           rr_r;
  logic                    out_valid_r;
  logic [W-1:0]            out_data_r;
  logic [SW-1:0]           out_src_r;
  logic [NCORE-1:0]        ovf_r;

  for (genvar i = 0; i < NCORE; i++) begin : g_fifo
    h2_console_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (phi),
      .rst_n (rst_n),
      .push  (cstrobe[i]),
      .pop   (pop_s[i]),
      .din   (cout[i*W +: W]),
      .dout  (head_s[i]),
      .empty (empty_s[i]),
      .full  (full_s[i])
    );
  end

  assign free_s        = ~out_valid_r | con.out_ready;
  assign cfull         = full_s;
  assign ovf           = ovf_r;
  assign con.out_valid = out_valid_r;
  assign con.out_data  = out_data_r;
  assign con.out_src   = out_src_r;

  // Round-robin search; walking from the far end lets the nearest candidate overwrite.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {SW{1'b0}};
    cand_s        = rr_r;
    for (int k = NCORE; k >= 1; k--) begin
      cand_s        = SW'(rr_index(32'(rr_r), 32'(k), 32'(NCORE)));
      grant_valid_s = grant_valid_s | ~empty_s[cand_s];
      grant_idx_s   = empty_s[cand_s] ? grant_idx_s : cand_s;
    end
  end

  // Pop only the winner, and only when the output register can take its head.
  always_comb begin
    pop_s              = {NCORE{1'b0}};
    pop_s[grant_idx_s] = free_s & grant_valid_s;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge phi) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= {SW{1'b0}};
      rr_r        <= SW'(NCORE - 1);
    end else if (free_s) begin
      if (grant_valid_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_s[grant_idx_s];
        out_src_r   <= grant_idx_s;
        rr_r        <= grant_idx_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Sticky drop flags: strobe into a full FIFO that is not draining this edge.
  always_ff @(posedge phi) begin
    if (!rst_n) begin
      ovf_r <= {NCORE{1'b0}};
    end else begin
      ovf_r <= ovf_r | (cstrobe & full_s & ~pop_s);
    end
  end

endmodule

// File: tb/tb_h2_console_arbiter.sv
// Bench for h2_console_arbiter: queue-based reference model, directed scenarios, random traffic.
module tb_h2_console_arbiter;
  import h2_console_pkg::*;

  localparam int NCORE = 4;
  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic               phi;
  logic               rst_n;
  logic [NCORE*W-1:0] cout;
  logic [NCORE-1:0]   cstrobe;
  logic [NCORE-1:0]   cfull;
  logic [NCORE-1:0]   ovf;

  h2_console_arbiter_if #(.NCORE(NCORE), .W(W)) con_if ();

  h2_console_arbiter #(.NCORE(NCORE), .W(W), .DEPTH(DEPTH)) dut (
    .phi     (phi),
    .rst_n   (rst_n),
    .cout    (cout),
    .cstrobe (cstrobe),
    .cfull   (cfull),
    .ovf     (ovf),
    .con     (con_if)
  );

  initial begin
    phi = 1'b0;
    forever #5 phi = ~phi;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-core byte lists, output slot, sticky drops, last grant.
  con_byte_t        mbuf [NCORE][DEPTH];
  int               mcnt [NCORE];
  bit               mv;
  con_byte_t        md;
  int               ms;
  logic [NCORE-1:0] movf;
  int               mrr;

  function automatic logic [NCORE-1:0] mfull();
    logic [NCORE-1:0] f;
    for (int i = 0; i < NCORE; i++) f[i] = (mcnt[i] == DEPTH);
    return f;
  endfunction

  task automatic model_step();
    bit nonempty [NCORE];
    bit free_now;
    int g;
    if (!rst_n) begin
      for (int i = 0; i < NCORE; i++) mcnt[i] = 0;
      mv = 1'b0; md = 8'h00; ms = 0; movf = 4'b0000; mrr = NCORE - 1;
      return;
    end
    for (int i = 0; i < NCORE; i++) nonempty[i] = (mcnt[i] > 0);
    free_now = !mv || con_if.out_ready;
    g = -1;
    for (int k = 1; k <= NCORE; k++) begin
      if (g < 0 && nonempty[(mrr + k) % NCORE]) g = (mrr + k) % NCORE;
    end
    if (free_now) begin
      if (g >= 0) begin
        md = mbuf[g][0];
        for (int j = 0; j < DEPTH - 1; j++) mbuf[g][j] = mbuf[g][j+1];
        mcnt[g]--;
        mv = 1'b1; ms = g; mrr = g;
      end else begin
        mv = 1'b0;
      end
    end
    for (int i = 0; i < NCORE; i++) begin
      if (cstrobe[i]) begin
        if (mcnt[i] < DEPTH) begin
          mbuf[i][mcnt[i]] = cout[i*W +: W];
          mcnt[i]++;
        end else begin
          movf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed value checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mdl_v, input logic [31:0] exp);
    check({name, " dut"}, dut_v, exp);
    check({name, " model"}, mdl_v, exp);
  endtask

  task automatic compare();
    check("out_valid", {31'd0, con_if.out_valid}, {31'd0, mv});
    if (mv) begin
      check("out_data", {24'd0, con_if.out_data}, {24'd0, md});
      check("out_src", {30'd0, con_if.out_src}, 32'(ms));
    end
    check("cfull", {28'd0, cfull}, {28'd0, mfull()});
    check("ovf", {28'd0, ovf}, {28'd0, movf});
  endtask

  // Inputs are set at the falling edge; model advances with the edge, compare at next fall.
  task automatic tick();
    model_step();
    @(posedge phi);
    @(negedge phi);
    compare();
  endtask

  task automatic strobe1(input int core, input logic [7:0] b);
    cstrobe = 4'b0000;
    cstrobe[core] = 1'b1;
    cout[core*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cstrobe = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cout = {8'h33, 8'h22, 8'h11, 8'h00};
    cstrobe = 4'b1111;
    con_if.out_ready = 1'b0;
    @(negedge phi);

    // Reset with strobes on every core.
    tick();
    tick();
    lit("rst out_valid", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);
    lit("rst out_data", {24'd0, con_if.out_data}, {24'd0, md}, 32'd0);
    lit("rst out_src", {30'd0, con_if.out_src}, 32'(ms), 32'd0);
    lit("rst cfull", {28'd0, cfull}, {28'd0, mfull()}, 32'd0);
    lit("rst ovf", {28'd0, ovf}, {28'd0, movf}, 32'd0);
    rst_n = 1'b1;
    cstrobe = 4'b0000;

    // Single byte from core 2.
    con_if.out_ready = 1'b1;
    strobe1(2, 8'h41);
    tick();
    lit("single E0 valid", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);
    cstrobe = 4'b0000;
    tick();
    lit("single E1 valid", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd1);
    lit("single E1 data", {24'd0, con_if.out_data}, {24'd0, md}, 32'h41);
    lit("single E1 src", {30'd0, con_if.out_src}, 32'(ms), 32'd2);
    tick();
    lit("single E2 valid", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);

    // Round-robin from reset: all cores strobe together.
    do_reset();
    con_if.out_ready = 1'b1;
    cstrobe = 4'b1111;
    cout = {8'h13, 8'h12, 8'h11, 8'h10};
    tick();
    cstrobe = 4'b0000;
    for (int i = 0; i < NCORE; i++) begin
      tick();
      lit("rr src", {30'd0, con_if.out_src}, 32'(ms), 32'(i));
      lit("rr data", {24'd0, con_if.out_data}, {24'd0, md}, 32'h10 + 32'(i));
    end
    tick();
    lit("rr drained", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);

    // Backpressure and overflow on core 1.
    do_reset();
    con_if.out_ready = 1'b0;
    strobe1(1, 8'hA0); tick();
    strobe1(1, 8'hA1); tick();
    lit("bp held A0", {24'd0, con_if.out_data}, {24'd0, md}, 32'hA0);
    strobe1(1, 8'hA2); tick();
    lit("bp cfull", {28'd0, cfull}, {28'd0, mfull()}, 32'b0010);
    lit("bp no ovf yet", {28'd0, ovf}, {28'd0, movf}, 32'b0000);
    strobe1(1, 8'hA3); tick();
    lit("bp ovf", {28'd0, ovf}, {28'd0, movf}, 32'b0010);
    lit("bp still A0", {24'd0, con_if.out_data}, {24'd0, md}, 32'hA0);
    cstrobe = 4'b0000;
    con_if.out_ready = 1'b1;
    tick();
    lit("bp A1", {24'd0, con_if.out_data}, {24'd0, md}, 32'hA1);
    tick();
    lit("bp A2", {24'd0, con_if.out_data}, {24'd0, md}, 32'hA2);
    tick();
    lit("bp no A3", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);

    // Push into a full FIFO on the edge it is popped.
    do_reset();
    con_if.out_ready = 1'b0;
    strobe1(0, 8'h50); tick();
    strobe1(0, 8'h51); tick();
    strobe1(0, 8'h52); tick();
    lit("fp cfull", {28'd0, cfull}, {28'd0, mfull()}, 32'b0001);
    con_if.out_ready = 1'b1;
    strobe1(0, 8'h55); tick();
    lit("fp data 51", {24'd0, con_if.out_data}, {24'd0, md}, 32'h51);
    lit("fp no ovf", {28'd0, ovf}, {28'd0, movf}, 32'b0000);
    cstrobe = 4'b0000;
    tick();
    lit("fp data 52", {24'd0, con_if.out_data}, {24'd0, md}, 32'h52);
    tick();
    lit("fp data 55", {24'd0, con_if.out_data}, {24'd0, md}, 32'h55);

    // Reset while a byte is held and another is buffered.
    do_reset();
    con_if.out_ready = 1'b0;
    strobe1(3, 8'h66); tick();
    strobe1(3, 8'h67); tick();
    lit("mr held", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd1);
    cstrobe = 4'b0000;
    rst_n = 1'b0;
    tick();
    lit("mr valid", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);
    lit("mr cfull", {28'd0, cfull}, {28'd0, mfull()}, 32'd0);
    rst_n = 1'b1;
    con_if.out_ready = 1'b1;
    tick();
    lit("mr empty", {31'd0, con_if.out_valid}, {31'd0, mv}, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < NCORE; i++) begin
        cstrobe[i] = ($urandom_range(0, 99) < 30);
        cout[i*W +: W] = 8'($urandom_range(0, 255));
      end
      con_if.out_ready = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 70 : 25));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
